// File: rtl/adbg_wb_burst_biu_pkg.sv
// Shared types and helpers for the debug Wishbone burst BIU.
// Covers CTI/BTE codes, FSM states, and the beat size/lane/byte-select decode.
package adbg_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        XFER  = 2'd2
    } biu_state_t;

    // Unsupported sizes fall back to a full-width beat.
    function automatic logic [3:0] size_norm(input logic [3:0] ws, input logic [3:0] nbytes);
        if (ws == 4'd1 || ws == 4'd2 || ws == 4'd4 || (ws == 4'd8 && nbytes == 4'd8))
            return ws;
        return nbytes;
    endfunction

    function automatic logic [2:0] lane_decode(input logic [3:0] size, input logic [2:0] addr_lo,
                                               input logic little_endian, input logic [3:0] nbytes);
        logic [3:0] lane;
        lane = {1'b0, addr_lo} & ~(size - 4'd1) & (nbytes - 4'd1);
        if (!little_endian)
            lane = nbytes - size - lane;
        return lane[2:0];
    endfunction

    function automatic logic [7:0] sel_decode(input logic [3:0] size, input logic [2:0] addr_lo,
                                              input logic little_endian, input logic [3:0] nbytes);
        logic [15:0] mask;
        mask = ((16'd1 << size) - 16'd1) << lane_decode(size, addr_lo, little_endian, nbytes);
        return mask[7:0];
    endfunction

endpackage

// File: rtl/adbg_wb_burst_biu_if.sv
// Wishbone B3 bus bundle between the debug BIU (master) and the interconnect (slave).
interface adbg_wb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_we_o;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [2:0]              wb_cti_o;
    logic [1:0]              wb_bte_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic                    wb_ack_i;
    logic                    wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/adbg_wb_burst_biu_fifo.sv
// Small synchronous read-data FIFO; pointers carry an extra MSB to tell full from empty.
module adbg_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A push into a full FIFO is fine when the head is leaving in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/adbg_wb_burst_biu.sv
// Debug-port Wishbone B3 burst master: one command becomes a single or incrementing burst.
// Optional ack timeout is compiled in with `define ADBG_WB_TIMEOUT_EN.
module adbg_wb_burst_biu
    import adbg_wb_pkg::*;
#(
    parameter int LITTLE_ENDIAN  = 1,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST      = 16,
    parameter int RFIFO_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          biu_clk,
    input  logic                          biu_rst_n,
    input  logic                          biu_strb,
    output logic                          biu_rdy,
    input  logic                          biu_rw,
    input  logic [ADDR_WIDTH-1:0]         biu_addr,
    input  logic [3:0]                    biu_word_size,
    input  logic [$clog2(MAX_BURST):0]    biu_burst_len,
    input  logic [DATA_WIDTH-1:0]         biu_di,
    input  logic                          biu_di_valid,
    output logic                          biu_di_ready,
    output logic [DATA_WIDTH-1:0]         biu_do,
    output logic                          biu_do_valid,
    input  logic                          biu_do_ready,
    output logic                          biu_err,
    output logic                          biu_busy,
    adbg_wb_if.master                     wb
);
    localparam int         NB     = DATA_WIDTH / 8;
    localparam int         LEN_W  = $clog2(MAX_BURST) + 1;
    localparam int         LANE_W = (NB == 8) ? 3 : 2;
    localparam logic [3:0] NB4    = 4'(NB);

    biu_state_t            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [3:0]            size_reg, size_next;
    logic [LEN_W-1:0]      rem_reg, rem_next;
    logic                  rw_reg, rw_next;
    logic                  burst_reg, burst_next;
    logic                  err_reg, err_next;
    logic                  beat_reg, beat_next;
    logic [DATA_WIDTH-1:0] dat_reg, dat_next;

    logic                  cyc, stb, push, timeout;
    logic                  fifo_full, fifo_empty;
    logic [LEN_W-1:0]      cmd_len;
    logic [2:0]            addr_lo, lane;
    logic [7:0]            sel_full;
    logic [DATA_WIDTH-1:0] di_masked, rd_shifted, rd_steered, wr_steered;

    assign addr_lo  = 3'(addr_reg[LANE_W-1:0]);
    assign lane     = lane_decode(size_reg, addr_lo, LITTLE_ENDIAN != 0, NB4);
    assign sel_full = sel_decode(size_reg, addr_lo, LITTLE_ENDIAN != 0, NB4);

    // Write data is right-justified on input; read data leaves right-justified and zero-filled.
    assign rd_shifted = wb.wb_dat_i >> {lane, 3'b000};
    assign wr_steered = di_masked << {lane, 3'b000};
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign di_masked[8*gi +: 8]  = (4'(gi) < size_reg) ? biu_di[8*gi +: 8] : 8'h00;
        assign rd_steered[8*gi +: 8] = (4'(gi) < size_reg) ? rd_shifted[8*gi +: 8] : 8'h00;
    end

    always_comb begin
        cmd_len = biu_burst_len;
        if (biu_burst_len == '0)
            cmd_len = LEN_W'(1);
        else if (biu_burst_len > LEN_W'(MAX_BURST))
            cmd_len = LEN_W'(MAX_BURST);
    end

    // cyc stays up between write beats so the burst is not broken while data trickles in.
    assign cyc = (state_reg == XFER) || (state_reg == WDATA && beat_reg);
    assign stb = (state_reg == XFER) && (!rw_reg || !fifo_full);

`ifdef ADBG_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_reg;

    always_ff @(posedge biu_clk or negedge biu_rst_n) begin
        if (!biu_rst_n)
            tmo_reg <= '0;
        else if (!stb || wb.wb_ack_i || wb.wb_err_i || timeout)
            tmo_reg <= '0;
        else
            tmo_reg <= tmo_reg + 1'b1;
    end

    assign timeout = stb && (tmo_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    // No watchdog: a beat waits for its slave indefinitely.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge biu_clk or negedge biu_rst_n) begin
        if (!biu_rst_n) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            size_reg  <= '0;
            rem_reg   <= '0;
            rw_reg    <= 1'b0;
            burst_reg <= 1'b0;
            err_reg   <= 1'b0;
            beat_reg  <= 1'b0;
            dat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            size_reg  <= size_next;
            rem_reg   <= rem_next;
            rw_reg    <= rw_next;
            burst_reg <= burst_next;
            err_reg   <= err_next;
            beat_reg  <= beat_next;
            dat_reg   <= dat_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        size_next    = size_reg;
        rem_next     = rem_reg;
        rw_next      = rw_reg;
        burst_next   = burst_reg;
        err_next     = err_reg;
        beat_next    = beat_reg;
        dat_next     = dat_reg;
        biu_rdy      = 1'b0;
        biu_di_ready = 1'b0;
        push         = 1'b0;
        case (state_reg)
            IDLE: begin
                biu_rdy = 1'b1;
                if (biu_strb) begin
                    addr_next  = biu_addr;
                    size_next  = size_norm(biu_word_size, NB4);
                    rem_next   = cmd_len;
                    burst_next = (cmd_len != LEN_W'(1));
                    rw_next    = biu_rw;
                    err_next   = 1'b0;
                    beat_next  = 1'b0;
                    state_next = biu_rw ? XFER : WDATA;
                end
            end
            WDATA: begin
                biu_di_ready = 1'b1;
                if (biu_di_valid) begin
                    dat_next   = wr_steered;
                    state_next = XFER;
                end
            end
            XFER: begin
                // Error beats win over a simultaneous ack and never reach the FIFO.
                if (stb && (wb.wb_err_i || timeout)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else if (stb && wb.wb_ack_i) begin
                    rem_next  = rem_reg - LEN_W'(1);
                    addr_next = addr_reg + ADDR_WIDTH'(size_reg);
                    beat_next = 1'b1;
                    push      = rw_reg;
                    if (rem_reg == LEN_W'(1))
                        state_next = IDLE;
                    else if (!rw_reg)
                        state_next = WDATA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    adbg_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RFIFO_DEPTH)
    ) u_rfifo (
        .clk   (biu_clk),
        .rst_n (biu_rst_n),
        .push  (push),
        .wdata (rd_steered),
        .pop   (biu_do_ready),
        .rdata (biu_do),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign biu_do_valid = !fifo_empty;
    assign biu_err      = err_reg;
    assign biu_busy     = (state_reg != IDLE);

    assign wb.wb_cyc_o = cyc;
    assign wb.wb_stb_o = stb;
    assign wb.wb_we_o  = cyc && !rw_reg;
    assign wb.wb_adr_o = addr_reg;
    assign wb.wb_sel_o = cyc ? sel_full[NB-1:0] : '0;
    assign wb.wb_dat_o = dat_reg;
    assign wb.wb_cti_o = !cyc       ? CTI_CLASSIC :
                         !burst_reg ? CTI_CLASSIC :
                         (rem_reg == LEN_W'(1)) ? CTI_EOB : CTI_INCR;
    assign wb.wb_bte_o = BTE_LINEAR;
endmodule

// File: doc/adbg_wb_burst_biu.md
Name: adbg_wb_burst_biu

Overview:
Single-clock Wishbone B3 bus master for the SoC debug interface, replacing the toggle-synchronised single-beat BIU.
- Accepts one command: address, access size, read/write, beat count.
- Executes it as a single access or an incrementing burst (CTI/BTE), byte-lane steered for any DATA_WIDTH.
- Write data streams in, and read data streams out through a small FIFO with backpressure.
- Sits between the debug module command decoder and the system Wishbone interconnect; both run on biu_clk.

Parameters:
LITTLE_ENDIAN, 1, lane order for sub-word accesses (1: byte 0 on dat[7:0])
ADDR_WIDTH, 32, Wishbone address width (byte address)
DATA_WIDTH, 32, Wishbone data width; 32 or 64
MAX_BURST, 16, maximum beats per command; power of 2, ≥1
RFIFO_DEPTH, 4, read-data FIFO depth; power of 2, ≥2
TIMEOUT_CYCLES, 255, ack timeout; used only with the optional feature

Ports:
biu_clk  in  1  clock (also Wishbone clock)
biu_rst_n  in  1  asynchronous active-low reset
biu_strb  in  1  command valid
biu_rdy  out  1  command ready; accepted when biu_strb & biu_rdy
biu_rw  in  1  1 = read, 0 = write
biu_addr  in  ADDR_WIDTH  start byte address
biu_word_size  in  4  bytes per beat: 1, 2, 4, or 8 (8 only if DATA_WIDTH=64); other values mean full width
biu_burst_len  in  $clog2(MAX_BURST)+1  beats; 0 is treated as 1, values above MAX_BURST are clamped
biu_di  in  DATA_WIDTH  write data, right-justified
biu_di_valid  in  1  write data valid
biu_di_ready  out  1  write data accepted
biu_do  out  DATA_WIDTH  read data, right-justified, zero-filled
biu_do_valid  out  1  read FIFO not empty
biu_do_ready  in  1  pop read FIFO
biu_err  out  1  sticky error for the current/last command
biu_busy  out  1  command in progress
wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone control
wb_adr_o  out  ADDR_WIDTH  address
wb_sel_o  out  DATA_WIDTH/8  byte selects
wb_dat_o  out  DATA_WIDTH  write data
wb_cti_o  out  3  cycle type
wb_bte_o  out  2  burst type; constant 2'b00 (linear)
wb_dat_i  in  DATA_WIDTH  read data
wb_ack_i, wb_err_i  in  1  responses

Behaviour:
- Reset values:
  - 0: wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o, biu_err, biu_busy, biu_di_ready, biu_do_valid.
  - wb_cti_o = 3'b000.
  - biu_rdy = 1.
  - Read FIFO empty.
  - Reset mid-burst drops cyc/stb asynchronously and discards the FIFO.
- FSM states: IDLE, WDATA, XFER.
  - IDLE: biu_rdy=1. On accept:
    - latch address, size and beat count (rem = clamped length); clear biu_err.
    - Write command: go to WDATA.
    - Read command: go to XFER.
  - WDATA: biu_di_ready=1. On biu_di_valid, lane-steer biu_di into wb_dat_o, then go to XFER.
  - XFER: cyc=stb=1.
    - Reads assert stb only while the FIFO has a free slot; otherwise cyc stays 1 and stb is 0.
    - On ack: rem-=1, address += word_size; reads push the steered wb_dat_i.
    - If rem was 1, drop cyc/stb in the next cycle and go to IDLE.
    - Otherwise a write returns to WDATA and a read stays in XFER.
  - wb_err_i in XFER: set biu_err, terminate immediately (cyc=0), go to IDLE, push nothing.
- Handshake timing:
  - biu_rdy is low from the cycle after accept until back in IDLE.
  - biu_busy = !IDLE.
- CTI rules:
  - Single beat: 000.
  - Burst: 010 on every beat except the last, which is 111.
  - For writes, CTI is 010 only while further data is known; a write burst stalled in WDATA drops stb (cyc held).
- Byte lanes:
  - sel = ((1<<word_size)-1) << lane.
  - lane = addr[log2(DATA_WIDTH/8)-1:0] aligned down to word_size.
  - Big-endian mirrors the lane index.
  - Address low bits are not realigned; misaligned requests are truncated to the aligned lane.
- Address arithmetic: incremented modulo 2^ADDR_WIDTH; a wrap is permitted and not flagged.
- Simultaneous ack and err: err wins.
- A FIFO pop and push in the same cycle while full is allowed.

Optional Feature:
- Macro ADBG_WB_TIMEOUT_EN.
- Defined: a counter is cleared on each stb-assertion and on ack/err, and increments while stb=1 and no response arrives. On reaching TIMEOUT_CYCLES, the beat is treated as wb_err_i: biu_err=1, bus released, FSM to IDLE.
- Undefined: no counter; the master waits indefinitely.

Decomposition:
- Package adbg_wb_pkg holds:
  - CTI constants: CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111.
  - BTE_LINEAR=00.
  - The FSM state enum typedef.
  - Function sel_decode(size, addr_lo, little_endian).
- Sub-module adbg_sync_fifo (WIDTH, DEPTH): read buffer with push/pop/full/empty, pointer wrap by extra MSB.

Test Plan:
- Single 32-bit write, addr 0x100, data 0xDEADBEEF, ack after 2 wait states → one cycle with cti=000, sel=1111, then biu_rdy back to 1 with biu_err=0.
- Byte read at 0x103, LE, wb_dat_i=0x11223344 → sel=1000, biu_do=0x00000011.
- Read burst of 8 from 0x0 with biu_do_ready=0 and RFIFO_DEPTH=4 → 4 acks, then stb=0 with cyc=1; after popping, the remaining 4 beats complete; address stepping is 0x0,0x4..0x1C, cti 010×7 then 111.
- Write burst of 3 with biu_di_valid gapped by 5 cycles → stb drops during gaps while cyc stays 1; wb_dat_o matches each beat.
- wb_err_i on beat 2 of a 4-beat read → cyc drops next cycle, biu_err=1, only 1 FIFO entry; the next command clears biu_err.
- ADBG_WB_TIMEOUT_EN with TIMEOUT_CYCLES=10 and no ack → cyc released after 10 cycles, biu_err=1. Reset asserted mid-burst → all outputs at reset values immediately.
